// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared vending types: FSM states, coin codes and coin values.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_20 = 2'd3;

  localparam int COIN_VAL_W = 5;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      COIN_1:  return 5'd1;
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      default: return 5'd20;
    endcase
  endfunction

endpackage

// File: rtl/vending_stock.sv
// rtl/vending_stock.sv - per-item stock counters with restock, saturating take and sold-out flags.
module vending_stock
  import vending_pkg::*;
#(
  parameter int N_ITEMS    = 5,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 9,
  parameter int IDX_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restock,
  input  logic               take,
  input  logic [IDX_W-1:0]   take_idx,
  output logic [N_ITEMS-1:0] sold_out
);

  localparam logic [STOCK_W-1:0] INIT_LOAD = STOCK_W'(INIT_STOCK);

  logic [STOCK_W-1:0] stock   [N_ITEMS];
  logic [STOCK_W-1:0] stock_n [N_ITEMS];
  logic [STOCK_W-1:0] base;

  // A take in the restock cycle decrements the freshly loaded count.
  always_comb begin
    base = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      base = restock ? INIT_LOAD : stock[i];
      stock_n[i] = base;
      if (take && (take_idx == IDX_W'(i)) && (base != '0)) begin
        stock_n[i] = base - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (rst) begin
        stock[i] <= INIT_LOAD;
      end else begin
        stock[i] <= stock_n[i];
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      sold_out[i] = (stock[i] == '0);
    end
  end

endmodule

// File: rtl/vending_core.sv
// rtl/vending_core.sv - vending controller: coin credit, cursor, purchase, refund and dispense pulses.
module vending_core
  import vending_pkg::*;
#(
  parameter int                          N_ITEMS    = 5,
  parameter int                          CREDIT_W   = 8,
  parameter int                          MAX_CREDIT = 79,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd8, 8'd10, 8'd6, 8'd5, 8'd7},
  parameter int                          STOCK_W    = 4,
  parameter int                          INIT_STOCK = 9,
  localparam int                         IDX_W      = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                L_button,
  input  logic                R_button,
  input  logic                C_button,
  input  logic                refund,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic [IDX_W-1:0]    sel_idx,
  output logic [N_ITEMS-1:0]  avail,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_idx,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                buy_reject
);

  localparam int              CW       = CREDIT_W + 1;
  localparam logic [CW-1:0]   MAX_EXT  = CW'(MAX_CREDIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

  state_t              state, state_n;
  logic                ready;
  logic                do_refund;
  logic                buy_ok;
  logic                buy_rej;
  logic                coin_ok;
  logic [CW-1:0]       credit_ext;
  logic [CW-1:0]       price_sel;
  logic [CW-1:0]       post_buy;
  logic [CW-1:0]       coin_sum;
  logic [CREDIT_W-1:0] credit_n;
  logic [IDX_W-1:0]    sel_n;

  vending_stock #(
    .N_ITEMS   (N_ITEMS),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK),
    .IDX_W     (IDX_W)
  ) u_stock (
    .clk     (clk),
    .rst     (rst),
    .restock (restock),
    .take    (buy_ok),
    .take_idx(sel_idx),
    .sold_out(sold_out)
  );

  // avail decodes only registered credit and stock, so it moves with them.
  always_comb begin
    avail = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      avail[i] = ({1'b0, credit} >= {1'b0, PRICES[i*CREDIT_W +: CREDIT_W]}) && !sold_out[i];
    end
  end

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        price_sel = {1'b0, PRICES[i*CREDIT_W +: CREDIT_W]};
      end
    end
  end

  always_comb begin
    state_n    = state;
    credit_ext = {1'b0, credit};
    ready      = (state == ST_IDLE) || (state == ST_BROWSE);
    do_refund  = ready && refund;
    buy_ok     = (state == ST_BROWSE) && C_button && !refund && avail[sel_idx];
    buy_rej    = ready && C_button && !refund && !buy_ok;
    // The coin is judged against the credit left after this cycle's purchase.
    post_buy   = buy_ok ? (credit_ext - price_sel) : credit_ext;
    coin_sum   = post_buy + CW'(coin_value(coin_sel));
    coin_ok    = coin_valid && ready && !refund && (coin_sum <= MAX_EXT);

    if (do_refund) begin
      credit_n = '0;
    end else if (coin_ok) begin
      credit_n = coin_sum[CREDIT_W-1:0];
    end else begin
      credit_n = post_buy[CREDIT_W-1:0];
    end

    case (state)
      ST_IDLE, ST_BROWSE: begin
        if (do_refund) begin
          state_n = ST_REFUND;
        end else if (buy_ok) begin
          state_n = ST_VEND;
        end else begin
          state_n = (credit_n != '0) ? ST_BROWSE : ST_IDLE;
        end
      end
      default: state_n = (credit != '0) ? ST_BROWSE : ST_IDLE;
    endcase

    sel_n = sel_idx;
    if ((L_button ^ R_button) && (state != ST_VEND)) begin
      if (L_button) begin
        sel_n = (sel_idx == '0) ? LAST_IDX : sel_idx - 1'b1;
      end else begin
        sel_n = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit       <= '0;
      sel_idx      <= '0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      buy_reject   <= 1'b0;
    end else begin
      credit       <= credit_n;
      sel_idx      <= sel_n;
      vend_valid   <= buy_ok;
      vend_idx     <= buy_ok ? sel_idx : '0;
      change_valid <= do_refund;
      change_amt   <= do_refund ? credit : '0;
      coin_reject  <= coin_valid && !coin_ok;
      buy_reject   <= buy_rej;
    end
  end

endmodule

// File: tb/tb_vending_core.sv
// tb/tb_vending_core.sv - self-checking bench for vending_core: vector table, corner sequences, random vs model.
module tb_vending_core;

  localparam int N = 5;
  localparam int MAXC = 79;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel = 2'd0;
  logic       L_button = 1'b0, R_button = 1'b0, C_button = 1'b0;
  logic       refund = 1'b0, restock = 1'b0;
  logic [7:0] credit;
  logic [2:0] sel_idx;
  logic [4:0] avail, sold_out;
  logic       vend_valid;
  logic [2:0] vend_idx;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject, buy_reject;

  vending_core dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .L_button(L_button), .R_button(R_button), .C_button(C_button),
    .refund(refund), .restock(restock), .credit(credit), .sel_idx(sel_idx),
    .avail(avail), .sold_out(sold_out), .vend_valid(vend_valid), .vend_idx(vend_idx),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .buy_reject(buy_reject)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int price [N] = '{7, 5, 6, 10, 8};
  int coinv [4] = '{1, 5, 10, 20};

  // Reference model: plain integers, a busy phase and a stock array.
  int m_credit, m_sel, m_phase;
  int m_stock [N];
  bit m_vend, m_chg, m_crej, m_brej;
  int m_vidx, m_amt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit cv, input int cs, input bit l, input bit r,
                            input bit c, input bit rf, input bit rs, input bit rt);
    bit bought;
    int bidx, nxt;
    m_vend = 0; m_vidx = 0; m_chg = 0; m_amt = 0; m_crej = 0; m_brej = 0;
    if (rt) begin
      m_credit = 0; m_sel = 0; m_phase = 0;
      foreach (m_stock[i]) m_stock[i] = 9;
      return;
    end
    bought = 0;
    bidx = m_sel;
    nxt = 0;
    if (m_phase == 0) begin
      if (rf) begin
        m_chg = 1; m_amt = m_credit; m_credit = 0; m_crej = cv; nxt = 2;
      end else begin
        if (c) begin
          if (m_credit > 0 && m_credit >= price[m_sel] && m_stock[m_sel] > 0) begin
            bought = 1; m_credit -= price[m_sel]; m_vend = 1; m_vidx = m_sel;
          end else begin
            m_brej = 1;
          end
        end
        if (cv) begin
          if (m_credit + coinv[cs] <= MAXC) m_credit += coinv[cs];
          else m_crej = 1;
        end
        nxt = bought ? 1 : 0;
      end
    end else begin
      m_crej = cv;
    end
    if (rs) foreach (m_stock[i]) m_stock[i] = 9;
    if (bought && m_stock[bidx] > 0) m_stock[bidx]--;
    if (l != r && m_phase != 1) m_sel = l ? (m_sel + N - 1) % N : (m_sel + 1) % N;
    m_phase = nxt;
  endtask

  task automatic check_model();
    logic [4:0] ea, es;
    ea = '0; es = '0;
    for (int i = 0; i < N; i++) begin
      ea[i] = (m_credit >= price[i]) && (m_stock[i] > 0);
      es[i] = (m_stock[i] == 0);
    end
    chk("m_credit", credit, m_credit);
    chk("m_sel", sel_idx, m_sel);
    chk("m_avail", avail, ea);
    chk("m_sold_out", sold_out, es);
    chk("m_vend_valid", vend_valid, m_vend);
    chk("m_vend_idx", vend_idx, m_vidx);
    chk("m_change_valid", change_valid, m_chg);
    chk("m_change_amt", change_amt, m_amt);
    chk("m_coin_reject", coin_reject, m_crej);
    chk("m_buy_reject", buy_reject, m_brej);
  endtask

  task automatic step(input bit cv, input int cs, input bit l, input bit r,
                      input bit c, input bit rf, input bit rs, input bit rt);
    coin_valid = cv; coin_sel = 2'(cs); L_button = l; R_button = r;
    C_button = c; refund = rf; restock = rs; rst = rt;
    @(posedge clk);
    model_step(cv, cs, l, r, c, rf, rs, rt);
    #1;
    check_model();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int cs);
    step(1, cs, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit cv; int cs; bit l; bit r; bit c; bit rf;
    int e_credit; int e_sel; bit e_vend; bit e_crej; bit e_brej; bit e_chg; int e_amt;
  } vec_t;

  function automatic vec_t v(input bit cv, input int cs, input bit l, input bit r,
                             input bit c, input bit rf, input int ecr, input int esel,
                             input bit evd, input bit ecj, input bit ebj, input bit ech,
                             input int eam);
    vec_t t;
    t.cv = cv; t.cs = cs; t.l = l; t.r = r; t.c = c; t.rf = rf;
    t.e_credit = ecr; t.e_sel = esel; t.e_vend = evd; t.e_crej = ecj;
    t.e_brej = ebj; t.e_chg = ech; t.e_amt = eam;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    //           cv cs l r c rf  credit sel vend crej brej chg amt
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  4, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  4, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 0,  4, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  4, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 60, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 70, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 75, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 75, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 76, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 76));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_credit", credit, 0);
    chk("reset_sel", sel_idx, 0);
    chk("reset_sold_out", sold_out, 0);
    chk("reset_pulses", {vend_valid, change_valid, coin_reject, buy_reject}, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].cv, tbl[k].cs, tbl[k].l, tbl[k].r, tbl[k].c, tbl[k].rf, 0, 0);
      chk($sformatf("vec%0d_credit", k), credit, tbl[k].e_credit);
      chk($sformatf("vec%0d_sel", k), sel_idx, tbl[k].e_sel);
      chk($sformatf("vec%0d_vend", k), vend_valid, tbl[k].e_vend);
      chk($sformatf("vec%0d_coin_reject", k), coin_reject, tbl[k].e_crej);
      chk($sformatf("vec%0d_buy_reject", k), buy_reject, tbl[k].e_brej);
      chk($sformatf("vec%0d_change_valid", k), change_valid, tbl[k].e_chg);
      chk($sformatf("vec%0d_change_amt", k), change_amt, tbl[k].e_amt);
      if (k == 1) chk("vec1_avail", avail, 5'b11111);
    end

    // Exhaust item1, then a rejected buy and a restock.
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      coin(1);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      chk("item1_vend", {vend_valid, vend_idx}, {1'b1, 3'd1});
      nop();
    end
    chk("item1_sold_out", sold_out[1], 1);
    coin(3);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("soldout_buy_reject", buy_reject, 1);
    chk("soldout_credit", credit, 20);
    chk("soldout_flag", sold_out[1], 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("restock_sold_out", sold_out, 0);

    // Refund beats a simultaneous coin and buy.
    step(0, 0, 0, 0, 0, 1, 0, 0);
    nop();
    coin(2); coin(0); coin(0); coin(0);
    chk("pre_refund_credit", credit, 13);
    step(1, 1, 0, 0, 1, 1, 0, 0);
    chk("refund_amt", change_amt, 13);
    chk("refund_valid", change_valid, 1);
    chk("refund_coin_reject", coin_reject, 1);
    chk("refund_no_vend", vend_valid, 0);
    chk("refund_no_buy_reject", buy_reject, 0);
    chk("refund_credit", credit, 0);
    nop();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("idle_buy_reject", buy_reject, 1);

    // Reset overrides a buy and a post-vend coin.
    coin(2);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    chk("rst_buy_vend", vend_valid, 0);
    chk("rst_buy_credit", credit, 0);
    coin(2);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("vend_before_rst", vend_valid, 1);
    step(1, 2, 1, 0, 0, 1, 0, 1);
    chk("rst_in_vend", {vend_valid, change_valid, coin_reject, credit}, 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 99) < 35, $urandom_range(0, 3),
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
           $urandom_range(0, 199) < 2, $urandom_range(0, 499) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
